// File: rtl/pwm_measure.sv
// pwm_measure: measures high time and period of a PWM line in clk cycles.
// Flags a line stuck high or low when no edge arrives within counter range.
module pwm_measure #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 pwm_in,
   output logic [CNT_WIDTH-1:0] high_time,
   output logic [CNT_WIDTH-1:0] period,
   output logic                 meas_valid,
   output logic                 stuck_high,
   output logic                 stuck_low
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_HIGH,
      S_LOW
   } state_t;

   state_t state;

   logic pwm_m;
   logic pwm_s;
   logic pwm_d;
   logic rise;
   logic fall;
   logic timeout;

   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_inc;
   logic [CNT_WIDTH-1:0] hi_lat;

   // Two-flop synchroniser plus one delay flop for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_m <= 1'b0;
         pwm_s <= 1'b0;
         pwm_d <= 1'b0;
      end else begin
         pwm_m <= pwm_in;
         pwm_s <= pwm_m;
         pwm_d <= pwm_s;
      end
   end

   assign rise    = pwm_s & ~pwm_d;
   assign fall    = ~pwm_s & pwm_d;
   assign timeout = (cnt == CNT_MAX);

   // Saturating increment so the counter can never wrap
   always_comb begin
      cnt_inc = cnt;
      if (cnt != CNT_MAX) begin
         cnt_inc = cnt + CNT_ONE;
      end
   end

   // Measurement FSM: counts cycles between detected edges and
   // publishes a high_time/period pair on every rise after the first
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         cnt        <= '0;
         hi_lat     <= '0;
         high_time  <= '0;
         period     <= '0;
         meas_valid <= 1'b0;
         stuck_high <= 1'b0;
         stuck_low  <= 1'b0;
      end else begin
         meas_valid <= 1'b0;
         if (!start) begin
            state      <= S_IDLE;
            cnt        <= '0;
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  cnt   <= '0;
                  state <= S_ARM;
               end
               S_ARM: begin
                  if (rise) begin
                     cnt   <= CNT_ONE;
                     state <= S_HIGH;
                  end else if (timeout) begin
                     if (pwm_s) begin
                        stuck_high <= 1'b1;
                     end else begin
                        stuck_low <= 1'b1;
                     end
                     cnt <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               S_HIGH: begin
                  if (fall) begin
                     hi_lat <= cnt;
                     cnt    <= cnt_inc;
                     state  <= S_LOW;
                  end else if (timeout) begin
                     stuck_high <= 1'b1;
                     cnt        <= '0;
                     state      <= S_ARM;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               S_LOW: begin
                  if (rise) begin
                     period     <= cnt;
                     high_time  <= hi_lat;
                     meas_valid <= 1'b1;
                     stuck_high <= 1'b0;
                     stuck_low  <= 1'b0;
                     cnt        <= CNT_ONE;
                     state      <= S_HIGH;
                  end else if (timeout) begin
                     stuck_low <= 1'b1;
                     cnt       <= '0;
                     state     <= S_ARM;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_measure.sv
// tb_pwm_measure: randomized PWM stimulus against a pulse-list model.
// Small counter width so stuck-line timeouts are reached quickly.
module tb_pwm_measure;

   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic         start;
   logic         pwm_in;
   logic [W-1:0] high_time;
   logic [W-1:0] period;
   logic         meas_valid;
   logic         stuck_high;
   logic         stuck_low;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int exp_ht[$];
   int exp_per[$];
   int got_ht[$];
   int got_per[$];
   int got_cyc[$];

   pwm_measure #(.CNT_WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pwm_in     (pwm_in),
      .high_time  (high_time),
      .period     (period),
      .meas_valid (meas_valid),
      .stuck_high (stuck_high),
      .stuck_low  (stuck_low)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Record every measurement pulse seen on the outputs
   always @(negedge clk) begin
      if (meas_valid === 1'b1) begin
         got_ht.push_back(int'(high_time));
         got_per.push_back(int'(period));
         got_cyc.push_back(cyc);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      exp_ht.delete();
      exp_per.delete();
      got_ht.delete();
      got_per.delete();
      got_cyc.delete();
   endtask

   task automatic idle_rearm();
      start  = 1'b0;
      pwm_in = 1'b0;
      repeat (4) step();
      clear_q();
      start = 1'b1;
      repeat (3) step();
   endtask

   // One PWM cycle; a following rise makes it a measured pulse
   task automatic pulse(input int h, input int l);
      pwm_in = 1'b1;
      repeat (h) step();
      pwm_in = 1'b0;
      repeat (l) step();
      exp_ht.push_back(h);
      exp_per.push_back(h + l);
   endtask

   task automatic close_rise();
      pwm_in = 1'b1;
      repeat (8) step();
   endtask

   task automatic test_reset();
      reset  = 1'b0;
      start  = 1'b0;
      pwm_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         pwm_in = ~pwm_in;
         step();
      end
      checks++;
      if (high_time !== 0 || period !== 0) begin
         errors++;
         $display("FAIL reset_meas: got ht=%0d per=%0d expected 0 0", high_time, period);
      end
      checks++;
      if (meas_valid !== 1'b0 || stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got mv=%b sh=%b sl=%b expected 0 0 0", meas_valid, stuck_high, stuck_low);
      end
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         pwm_in = (i % 3 == 0);
         step();
      end
      pwm_in = 1'b0;
      repeat (4) step();
      checks++;
      if (high_time !== 0 || period !== 0 || stuck_high !== 0 || stuck_low !== 0 || got_ht.size() != 0) begin
         errors++;
         $display("FAIL reset_idle: got ht=%0d per=%0d sh=%b sl=%b n=%0d expected all 0", high_time, period, stuck_high, stuck_low, got_ht.size());
      end
   endtask

   task automatic test_nominal();
      idle_rearm();
      pulse(10, 30);
      checks++;
      if (got_ht.size() != 0) begin
         errors++;
         $display("FAIL nominal_first: got %0d measurements expected 0 before 2nd rise", got_ht.size());
      end
      for (int i = 0; i < 3; i++) pulse(10, 30);
      close_rise();
      checks++;
      if (got_ht.size() != exp_ht.size()) begin
         errors++;
         $display("FAIL nominal_count: got %0d expected %0d", got_ht.size(), exp_ht.size());
      end else begin
         for (int i = 0; i < exp_ht.size(); i++) begin
            checks++;
            if (got_ht[i] != exp_ht[i] || got_per[i] != exp_per[i]) begin
               errors++;
               $display("FAIL nominal_meas[%0d]: got %0d/%0d expected %0d/%0d", i, got_ht[i], got_per[i], exp_ht[i], exp_per[i]);
            end
         end
         for (int i = 1; i < got_cyc.size(); i++) begin
            checks++;
            if (got_cyc[i] - got_cyc[i-1] != 40) begin
               errors++;
               $display("FAIL nominal_spacing[%0d]: got %0d expected 40", i, got_cyc[i] - got_cyc[i-1]);
            end
         end
      end
   endtask

   task automatic test_duty_change();
      idle_rearm();
      pulse(10, 30);
      pulse(10, 30);
      pulse(10, 32);
      for (int i = 0; i < 3; i++) pulse(32, 32);
      close_rise();
      checks++;
      if (got_ht.size() != exp_ht.size()) begin
         errors++;
         $display("FAIL duty_count: got %0d expected %0d", got_ht.size(), exp_ht.size());
      end else begin
         for (int i = 0; i < exp_ht.size(); i++) begin
            checks++;
            if (got_ht[i] != exp_ht[i] || got_per[i] != exp_per[i]) begin
               errors++;
               $display("FAIL duty_meas[%0d]: got %0d/%0d expected %0d/%0d", i, got_ht[i], got_per[i], exp_ht[i], exp_per[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      idle_rearm();
      for (int i = 0; i < 12; i++) begin
         pulse($urandom_range(1, 40), $urandom_range(1, 40));
      end
      close_rise();
      checks++;
      if (got_ht.size() != exp_ht.size()) begin
         errors++;
         $display("FAIL random_count: got %0d expected %0d", got_ht.size(), exp_ht.size());
      end else begin
         for (int i = 0; i < exp_ht.size(); i++) begin
            checks++;
            if (got_ht[i] != exp_ht[i] || got_per[i] != exp_per[i]) begin
               errors++;
               $display("FAIL random_meas[%0d]: got %0d/%0d expected %0d/%0d", i, got_ht[i], got_per[i], exp_ht[i], exp_per[i]);
            end
         end
      end
      checks++;
      if (stuck_high !== 1'b0 || stuck_low !== 1'b0) begin
         errors++;
         $display("FAIL random_stuck: got sh=%b sl=%b expected 0 0", stuck_high, stuck_low);
      end
   endtask

   task automatic test_stuck_low();
      int n;
      idle_rearm();
      repeat (245) step();
      checks++;
      if (stuck_low !== 1'b0) begin
         errors++;
         $display("FAIL stuck_low_early: got %b expected 0", stuck_low);
      end
      n = 0;
      while (stuck_low !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (stuck_low !== 1'b1 || stuck_high !== 1'b0 || got_ht.size() != 0) begin
         errors++;
         $display("FAIL stuck_low_set: got sl=%b sh=%b n=%0d expected 1 0 0", stuck_low, stuck_high, got_ht.size());
      end
      pulse(10, 30);
      checks++;
      if (stuck_low !== 1'b1) begin
         errors++;
         $display("FAIL stuck_low_sticky: got %b expected 1", stuck_low);
      end
      pulse(10, 30);
      close_rise();
      checks++;
      if (stuck_low !== 1'b0 || got_ht.size() != 2) begin
         errors++;
         $display("FAIL stuck_low_clear: got sl=%b n=%0d expected 0 2", stuck_low, got_ht.size());
      end else if (got_ht[0] != 10 || got_per[0] != 40) begin
         errors++;
         $display("FAIL stuck_low_meas: got %0d/%0d expected 10/40", got_ht[0], got_per[0]);
      end
   endtask

   task automatic test_stuck_high();
      int n;
      idle_rearm();
      pwm_in = 1'b1;
      repeat (250) step();
      checks++;
      if (stuck_high !== 1'b0) begin
         errors++;
         $display("FAIL stuck_high_early: got %b expected 0", stuck_high);
      end
      n = 0;
      while (stuck_high !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (stuck_high !== 1'b1 || stuck_low !== 1'b0) begin
         errors++;
         $display("FAIL stuck_high_set: got sh=%b sl=%b expected 1 0", stuck_high, stuck_low);
      end
      repeat (5) step();
      pwm_in = 1'b0;
      repeat (30) step();
      checks++;
      if (stuck_high !== 1'b1 || got_ht.size() != 0) begin
         errors++;
         $display("FAIL stuck_high_sticky: got sh=%b n=%0d expected 1 0", stuck_high, got_ht.size());
      end
      pulse(10, 30);
      close_rise();
      checks++;
      if (stuck_high !== 1'b0 || got_ht.size() != 1) begin
         errors++;
         $display("FAIL stuck_high_clear: got sh=%b n=%0d expected 0 1", stuck_high, got_ht.size());
      end else if (got_ht[0] != 10 || got_per[0] != 40) begin
         errors++;
         $display("FAIL stuck_high_meas: got %0d/%0d expected 10/40", got_ht[0], got_per[0]);
      end
   endtask

   task automatic test_abort();
      idle_rearm();
      pulse(10, 30);
      pulse(10, 30);
      pwm_in = 1'b1;
      repeat (8) step();
      start = 1'b0;
      step();
      start = 1'b1;
      repeat (12) step();
      pwm_in = 1'b0;
      repeat (20) step();
      pwm_in = 1'b1;
      repeat (12) step();
      pwm_in = 1'b0;
      repeat (28) step();
      checks++;
      if (got_ht.size() != 2 || high_time !== 10 || period !== 40) begin
         errors++;
         $display("FAIL abort_retain: got n=%0d ht=%0d per=%0d expected 2 10 40", got_ht.size(), high_time, period);
      end
      pwm_in = 1'b1;
      repeat (8) step();
      checks++;
      if (got_ht.size() != 3) begin
         errors++;
         $display("FAIL abort_resume_count: got %0d expected 3", got_ht.size());
      end else if (got_ht[2] != 12 || got_per[2] != 40) begin
         errors++;
         $display("FAIL abort_resume_meas: got %0d/%0d expected 12/40", got_ht[2], got_per[2]);
      end
      repeat (4) step();
      pwm_in = 1'b0;
      repeat (5) step();
      reset = 1'b0;
      #1;
      checks++;
      if (high_time !== 0 || period !== 0 || meas_valid !== 0 || stuck_high !== 0 || stuck_low !== 0) begin
         errors++;
         $display("FAIL abort_async_reset: got ht=%0d per=%0d mv=%b sh=%b sl=%b expected all 0", high_time, period, meas_valid, stuck_high, stuck_low);
      end
      step();
      reset = 1'b1;
      start = 1'b0;
      repeat (2) step();
   endtask

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      pwm_in = 1'b0;
      test_reset();
      test_nominal();
      test_duty_change();
      test_random();
      test_stuck_low();
      test_stuck_high();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
